// File: rtl/uart_tx_pkg.sv
// Shared types and line constants for the UART TX FIFO reader.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic START_LVL   = 1'b0;
  localparam logic STOP_LVL    = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high and
// raises bit_end combinationally during the terminal-count cycle.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(CLKS_PER_BIT - 1);

  logic [CNT_WIDTH-1:0] cnt;

  assign bit_end = run && (cnt == TERMINAL);

  // Counter wraps to zero at each bit end so the next bit starts fresh.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART TX FIFO reader: pops bytes from a show-ahead FIFO and serializes
// them as start / data (LSB first) / optional parity / stop frames.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo_reader
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_rempty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rinc,
  input  logic                  par_type,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      idx_next;
  logic                  tx_q;
  logic                  tx_next;
  logic                  bit_end;
  logic                  last_stop;
  logic                  pop;

`ifdef UART_TX_PARITY_EN
  logic par_q;
  logic par_next;
`else
  logic unused_par_type;
  assign unused_par_type = par_type;
`endif

  uart_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (pop),
    .run     (state != IDLE),
    .bit_end (bit_end)
  );

  assign fifo_rinc = pop;
  assign busy      = (state != IDLE);
  assign tx_out    = tx_q;

  // Next-state, pop decision and the line level for the following cycle.
  always_comb begin
    state_next = state;
    shift_next = shift_q;
    idx_next   = bit_idx;
    tx_next    = TX_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
    par_next   = par_q;
`endif
    last_stop  = (state == STOP) && bit_end;
    pop        = !rst && tx_en && !fifo_rempty && ((state == IDLE) || last_stop);
    frame_done = last_stop;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_q >> 1;
          if (bit_idx == LAST_IDX) begin
            idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = bit_idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (pop) begin
      shift_next = fifo_rdata;
      idx_next   = '0;
      state_next = START;
`ifdef UART_TX_PARITY_EN
      par_next   = (^fifo_rdata) ^ (par_type == PAR_ODD);
`endif
    end

    case (state_next)
      START:   tx_next = START_LVL;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      STOP:    tx_next = STOP_LVL;
      default: tx_next = TX_IDLE_LVL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers; the line itself is registered so it never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bit_idx <= '0;
      tx_q    <= TX_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_next;
      bit_idx <= idx_next;
      tx_q    <= tx_next;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Self-checking bench for uart_tx_fifo_reader: a FIFO model feeds the DUT,
// each observed pop queues the expected per-cycle line waveform of that
// frame, and a monitor compares the DUT outputs against it every cycle.
module tb_uart_tx_fifo_reader;

  localparam int DW   = 8;
  localparam int CLKS = 4;

  typedef struct packed {
    logic lvl;
    logic done;
  } samp_t;

  logic          clk;
  logic          rst;
  logic          tx_en;
  logic          fifo_rempty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rinc;
  logic          par_type;
  logic          tx_out;
  logic          busy;
  logic          frame_done;

  logic [DW-1:0] fq[$];
  samp_t         lq[$];
  logic          pop_pending;
  int            pop_count;
  int            checks;
  int            errors;

  uart_tx_fifo_reader #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CLKS),
    .CNT_WIDTH    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .par_type    (par_type),
    .tx_out      (tx_out),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic refreshFifo();
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  // Expected line waveform of one frame, built from the frame format.
  task automatic pushFrame(input logic [DW-1:0] d, input logic ptype);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^d) ^ ptype);
`endif
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < CLKS; c++)
        lq.push_back('{lvl: bits[b], done: (b == bits.size() - 1) && (c == CLKS - 1)});
    bits.delete();
  endtask

  // FIFO model removes the head word just after the edge that consumed it.
  always @(posedge clk) begin
    if (pop_pending) begin
      #1;
      void'(fq.pop_front());
      pop_pending = 1'b0;
      refreshFifo();
    end
  end

  // Monitor: compare every cycle against the expected waveform queue.
  initial begin
    samp_t cur;
    logic  has;
    logic  exp_pop;
    @(posedge clk);
    forever begin
      @(negedge clk);
      has     = (lq.size() != 0);
      exp_pop = !rst && tx_en && (fq.size() != 0) && (!has || lq[0].done);
      cur     = has ? lq.pop_front() : '{lvl: 1'b1, done: 1'b0};
      checkOutput("tx_out", 32'(tx_out), 32'(cur.lvl));
      checkOutput("busy", 32'(busy), 32'(has));
      if (!rst) checkOutput("frame_done", 32'(frame_done), 32'(cur.done));
      checkOutput("fifo_rinc", 32'(fifo_rinc), 32'(exp_pop));
      if (rst) begin
        lq.delete();
      end else if (fifo_rinc && fq.size() != 0) begin
        pushFrame(fq[0], par_type);
        pop_pending = 1'b1;
        pop_count++;
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] d);
    fq.push_back(d);
    refreshFifo();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (!(fq.size() == 0 && lq.size() == 0 && !pop_pending) && n < budget) begin
      cycles(1);
      n++;
    end
    checkOutput("idle_timeout", 32'(n < budget), 32'd1);
    cycles(2);
  endtask

  initial begin
    int base;
    int n;
    checks      = 0;
    errors      = 0;
    pop_count   = 0;
    pop_pending = 1'b0;
    rst         = 1'b1;
    tx_en       = 1'b1;
    par_type    = 1'b0;
    fq.delete();
    refreshFifo();

    // Reset with a non-empty FIFO, then a single 0xA5 frame.
    applyStimulus(8'hA5);
    cycles(3);
    checkOutput("reset_no_pop", 32'(pop_count), 32'd0);
    rst = 1'b0;
    waitIdle(200);
    checkOutput("single_pops", 32'(pop_count), 32'd1);

    // Back-to-back frames.
    base = pop_count;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    waitIdle(300);
    checkOutput("b2b_pops", 32'(pop_count - base), 32'd2);

    // Parity select, even then odd.
    par_type = 1'b0;
    applyStimulus(8'hA5);
    waitIdle(200);
    par_type = 1'b1;
    applyStimulus(8'hA5);
    cycles(8);
    par_type = 1'b0;
    waitIdle(200);

    // tx_en dropped mid-frame blocks further pops until reasserted.
    base = pop_count;
    applyStimulus(8'h3C);
    applyStimulus(8'hC3);
    applyStimulus(8'h5A);
    cycles(10);
    tx_en = 1'b0;
    cycles(100);
    checkOutput("txen_block_pops", 32'(pop_count - base), 32'd1);
    tx_en = 1'b1;
    waitIdle(400);
    checkOutput("txen_resume_pops", 32'(pop_count - base), 32'd3);

    // Reset during DATA bit 3: frame abandoned, next byte sent intact.
    base = pop_count;
    applyStimulus(8'h96);
    applyStimulus(8'h69);
    n = 0;
    while (pop_count == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset_pop_seen", 32'(pop_count - base), 32'd1);
    cycles(18);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    waitIdle(200);
    checkOutput("reset_pops", 32'(pop_count - base), 32'd2);

    // Randomized traffic with tx_en and par_type changing freely.
    base = pop_count;
    for (int i = 0; i < 1500; i++) begin
      if (fq.size() < 4 && $urandom_range(0, 7) == 0) applyStimulus(DW'($urandom));
      if ($urandom_range(0, 19) == 0) tx_en = ~tx_en;
      par_type = 1'($urandom);
      cycles(1);
    end
    tx_en = 1'b1;
    waitIdle(1000);
    checkOutput("random_some_pops", 32'(pop_count > base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
